mmul_opreg: RTL and testbench
=============================

# mmul_opreg

Parametrised operand register for the Montgomery multiplier and modular-divider datapath. It accepts a W-bit operand as W/D words over a valid/ready port, least-significant word first. It can then shift the operand right by a counted number of bits, one bit per cycle, with logical or arithmetic fill, and emit each shifted-out bit. It can also unload the operand word-serially by rotation, so the contents are preserved.

## Interface
- `W`, default 256: operand width; must be a multiple of `D`.
- `D`, default 16: load/unload word width; must satisfy 1 ≤ `D` ≤ `W`.
- `NW`, derived: `W/D`, the word count. Not overridable.
- `CW`, derived: `$clog2(W+1)`, the shift-count width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `clr` in 1: synchronous clear; same effect as `rst`.
- `ld_valid` in 1: load word offered.
- `ld_data` in D: load word.
- `ld_ready` out 1: load word accepted when high together with `ld_valid`.
- `full` out 1: all `NW` words loaded.
- `sh_start` in 1: start a counted right shift.
- `sh_count` in CW: number of bit positions to shift; sampled with `sh_start`.
- `sh_arith` in 1: fill select; 1 = replicate MSB, 0 = zero fill. Sampled with `sh_start`.
- `sh_busy` out 1: shift in progress.
- `sh_bit_valid` out 1: `sh_bit` is valid this cycle.
- `sh_bit` out 1: bit leaving position 0 this cycle.
- `sh_done` out 1: one-cycle pulse when a shift completes.
- `rd_start` in 1: start a word-serial unload.
- `rd_valid` out 1: unload word available.
- `rd_data` out D: unload word, equal to `regout[D-1:0]`.
- `rd_ready` in 1: unload word consumed.
- `regout` out W: parallel view of the register.

## Operation
- State machine states: IDLE, LOAD, SHIFT, UNLOAD.
- Internal counters:
  - word counter `wcnt`, range 0..NW;
  - bit counter `bcnt`, width CW.
- **Reset and clear:**
  - On `rst` or `clr`: `regout`=0, `wcnt`=0, `full`=0, state IDLE.
  - All handshake and status outputs are 0 in the following cycle.
  - Reset or clear overrides every other input, including mid-load, mid-shift and mid-unload.
- **Load:**
  - `ld_ready` = (state IDLE or LOAD) && !`full`.
  - On each accepted word: `regout` <= {`ld_data`, `regout[W-1:D]`}, and `wcnt`++. The state is LOAD while `wcnt` is between 0 and NW exclusive.
  - When the NW-th word is accepted: `full`=1, state IDLE.
  - The first word loaded ends up in `regout[D-1:0]`.
- **Shift:**
  - `sh_start` is honoured only in IDLE with `full`=1; it is ignored otherwise.
  - The shift amount N = min(`sh_count`, W). Values above W clamp to W, giving all-fill.
  - N=0: no state change; `sh_done` pulses on the next cycle.
  - N>0: the block is in SHIFT for exactly N cycles. Each cycle, `regout` <= {fill, `regout[W-1:1]`} and `sh_bit` = `regout[0]`.
  - Fill is `regout[W-1]` when `sh_arith`=1, else 0. The fill bit is re-evaluated each cycle, so the sign is preserved.
  - `full` remains 1 after a shift.
- **Unload:**
  - `rd_start` is honoured only in IDLE with `full`=1.
  - In UNLOAD, `rd_valid`=1. On each `rd_valid` && `rd_ready`: `regout` <= {`regout[D-1:0]`, `regout[W-1:D]`} (rotate).
  - After NW handshakes: state IDLE, `regout` is equal to its pre-unload value, `full` stays 1.
  - `rd_ready` low stalls the unload indefinitely, with `rd_data` held stable.
- **Simultaneous events in IDLE:** `sh_start` has priority over `rd_start`. Load cannot collide with either, since load requires `full`=0 and the others require `full`=1.

## Timing
- Accepted load, shift step and unload rotate all take effect at the edge; the result is visible on `regout` one cycle later.
- `full` rises in the cycle after the NW-th accepted word.
- `ld_ready`, `rd_valid`, `rd_data`, `sh_busy`, `sh_bit_valid` and `sh_bit` are decoded from registered state only. There is no combinational path from any input to any output.
- `sh_start` sampled at cycle t:
  - `sh_busy` and `sh_bit_valid` are high in cycles t+1 .. t+N;
  - `sh_done` pulses at t+N+1, when `regout` holds the final value;
  - total latency is N+1 cycles.
- `rd_start` sampled at cycle t: first `rd_valid` at t+1. Unload takes a minimum of NW cycles when `rd_ready` is held high.
- A new `sh_start` or `rd_start` may be sampled in the same cycle that `sh_done` is high.

## Structure
- Shared package `mmul_pkg`:
  - state enum `mmul_opreg_state_t`;
  - helper function `clamp_shift`;
  - default constants `MMUL_W`=256 and `MMUL_D`=16.
- One sub-module: `mmul_opreg_ctl`, holding the FSM plus `wcnt` and `bcnt`. It drives the enables and mux selects for the datapath register in the top level.
- Elaboration-time assertions: `W % D == 0` and `D <= W`.

## Test plan
- **Load:** W=32, D=8; load 0x11, 0x22, 0x33, 0x44 back-to-back.
  - Expect `regout`=0x44332211 and `full` one cycle after the 4th word.
  - A 5th `ld_valid` is refused (`ld_ready`=0).
- **Logical shift:** `regout`=0x80000003, `sh_count`=2, `sh_arith`=0.
  - Expect `sh_bit` = 1, 1 on consecutive cycles.
  - Expect `sh_done` at t+3 and `regout`=0x20000000.
- **Arithmetic shift and clamp:** `regout`=0x80000000, `sh_arith`=1, `sh_count`=33 (clamped to 32).
  - Expect 32 busy cycles and `regout`=0xFFFFFFFF.
  - With `sh_count`=0, expect `sh_done` at t+1 and `regout` unchanged.
- **Unload with backpressure:** `regout`=0x44332211; unload with `rd_ready` toggling 1,0,1,0,...
  - Expect `rd_data` sequence 0x11, 0x22, 0x33, 0x44, held stable across stalls.
  - Afterwards, expect `regout`=0x44332211 and `full`=1.
- **Priority:** `sh_start` and `rd_start` asserted in the same IDLE cycle. Expect SHIFT; no `rd_valid` appears.
- **Clear and reset mid-operation:**
  - `clr` in the 3rd SHIFT cycle: next cycle `regout`=0, `full`=0, `sh_busy`=0, no `sh_done`.
  - Repeat with `rst` mid-UNLOAD: same result.
  - Then reload at default W=256, D=16 with words 0x0001..0x0010; check `regout[15:0]`=0x0001 and `regout[255:240]`=0x0010.

Source files
------------

// File: rtl/mmul_pkg.sv
// mmul_pkg: shared types, defaults and helpers for the Montgomery/modular-divider
// operand register.
package mmul_pkg;

    localparam int MMUL_W = 256;
    localparam int MMUL_D = 16;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UNLOAD} mmul_opreg_state_t;

    function automatic int clamp_shift(input int count, input int width);
        return (count > width) ? width : count;
    endfunction

endpackage

// File: rtl/mmul_opreg_ctl.sv
// mmul_opreg_ctl: sequencing FSM with word and bit counters; drives the
// load/shift/rotate enables of the operand datapath register.
module mmul_opreg_ctl
    import mmul_pkg::*;
#(
    parameter  int W   = MMUL_W,
    parameter  int D   = MMUL_D,
    localparam int NW  = W / D,
    localparam int CW  = $clog2(W + 1),
    localparam int WCW = $clog2(NW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          ld_valid,
    output logic          ld_ready,
    output logic          full,
    input  logic          sh_start,
    input  logic [CW-1:0] sh_count,
    input  logic          sh_arith,
    output logic          sh_busy,
    output logic          sh_bit_valid,
    output logic          sh_done,
    input  logic          rd_start,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          ld_en,
    output logic          shift_en,
    output logic          rot_en,
    output logic          fill_arith
);

    mmul_opreg_state_t r_state;
    logic [WCW-1:0]    r_wcnt;
    logic [CW-1:0]     r_bcnt;
    logic              r_full;
    logic              r_arith;
    logic              r_done;
    logic              r_rst_d;
    logic [CW-1:0]     w_n;
    logic              w_idle_full;
    logic              w_rd_hs;
    logic              w_last_word;

    assign w_n          = CW'(clamp_shift(int'(sh_count), W));
    assign w_idle_full  = (r_state == IDLE) && r_full;
    assign w_last_word  = r_wcnt == WCW'(NW - 1);
    // r_rst_d holds ld_ready low for the cycle right after a reset or clear
    assign ld_ready     = (r_state == IDLE || r_state == LOAD) && !r_full && !r_rst_d;
    assign rd_valid     = r_state == UNLOAD;
    assign w_rd_hs      = rd_valid && rd_ready;
    assign sh_busy      = r_state == SHIFT;
    assign sh_bit_valid = sh_busy;
    assign sh_done      = r_done;
    assign full         = r_full;
    assign ld_en        = ld_valid && ld_ready;
    assign shift_en     = sh_busy;
    assign rot_en       = w_rd_hs;
    assign fill_arith   = r_arith;

    always_ff @(posedge clk) begin
        r_rst_d <= rst || clr;
        r_done  <= 1'b0;
        if (rst || clr) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
            r_bcnt  <= '0;
            r_full  <= 1'b0;
            r_arith <= 1'b0;
        end else begin
            case (r_state)
                IDLE, LOAD: begin
                    if (ld_en) begin
                        r_wcnt  <= r_wcnt + 1'b1;
                        r_full  <= w_last_word;
                        r_state <= w_last_word ? IDLE : LOAD;
                    end else if (w_idle_full && sh_start) begin
                        r_arith <= sh_arith;
                        r_bcnt  <= w_n;
                        if (w_n == '0)
                            r_done <= 1'b1;
                        else
                            r_state <= SHIFT;
                    end else if (w_idle_full && rd_start) begin
                        r_wcnt  <= '0;
                        r_state <= UNLOAD;
                    end
                end
                SHIFT: begin
                    r_bcnt <= r_bcnt - 1'b1;
                    if (r_bcnt == CW'(1)) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                UNLOAD: begin
                    if (w_rd_hs) begin
                        r_wcnt <= r_wcnt + 1'b1;
                        if (w_last_word)
                            r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mmul_opreg.sv
// mmul_opreg: W-bit operand register with word-serial load, counted right
// shift (logical/arithmetic) and non-destructive rotating unload.
module mmul_opreg
    import mmul_pkg::*;
#(
    parameter  int W  = MMUL_W,
    parameter  int D  = MMUL_D,
    localparam int NW = W / D,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          ld_valid,
    input  logic [D-1:0]  ld_data,
    output logic          ld_ready,
    output logic          full,
    input  logic          sh_start,
    input  logic [CW-1:0] sh_count,
    input  logic          sh_arith,
    output logic          sh_busy,
    output logic          sh_bit_valid,
    output logic          sh_bit,
    output logic          sh_done,
    input  logic          rd_start,
    output logic          rd_valid,
    output logic [D-1:0]  rd_data,
    input  logic          rd_ready,
    output logic [W-1:0]  regout
);

    if ((W % D) != 0 || D < 1 || D > W) begin : g_bad_params
        $error("mmul_opreg: W must be a multiple of D and 1 <= D <= W");
    end

    logic [W-1:0] r_reg;
    logic         w_ld_en;
    logic         w_shift_en;
    logic         w_rot_en;
    logic         w_fill_arith;
    logic         w_fill;

    mmul_opreg_ctl #(.W(W), .D(D)) u_ctl (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .full         (full),
        .sh_start     (sh_start),
        .sh_count     (sh_count),
        .sh_arith     (sh_arith),
        .sh_busy      (sh_busy),
        .sh_bit_valid (sh_bit_valid),
        .sh_done      (sh_done),
        .rd_start     (rd_start),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .ld_en        (w_ld_en),
        .shift_en     (w_shift_en),
        .rot_en       (w_rot_en),
        .fill_arith   (w_fill_arith)
    );

    assign w_fill = w_fill_arith & r_reg[W-1];

    // concatenate-and-shift forms stay legal when D == W
    always_ff @(posedge clk) begin
        if (rst || clr)
            r_reg <= '0;
        else if (w_ld_en)
            r_reg <= W'({ld_data, r_reg} >> D);
        else if (w_shift_en)
            r_reg <= W'({w_fill, r_reg} >> 1);
        else if (w_rot_en)
            r_reg <= W'({r_reg[D-1:0], r_reg} >> D);
    end

    assign regout  = r_reg;
    assign rd_data = r_reg[D-1:0];
    assign sh_bit  = r_reg[0];

endmodule

// File: tb/tb_mmul_opreg.sv
// tb_mmul_opreg: directed and randomized checks of mmul_opreg against an
// arithmetic reference model (W=32/D=8 instance plus a default-size instance).
module tb_mmul_opreg;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int NW = 4;
    localparam int CW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, clr, ld_valid, sh_start, sh_arith, rd_start, rd_ready;
    logic [D-1:0]  ld_data;
    logic [CW-1:0] sh_count;
    logic          ld_ready, full, sh_busy, sh_bit_valid, sh_bit, sh_done, rd_valid;
    logic [D-1:0]  rd_data;
    logic [W-1:0]  regout;

    logic          b_rst, b_clr, b_ld_valid;
    logic [15:0]   b_ld_data;
    logic          b_ld_ready, b_full, b_sh_busy, b_sh_bit_valid, b_sh_bit, b_sh_done, b_rd_valid;
    logic [15:0]   b_rd_data;
    logic [255:0]  b_regout;

    int checks = 0;
    int errors = 0;
    logic [31:0] m;

    mmul_opreg #(.W(W), .D(D)) dut (
        .clk(clk), .rst(rst), .clr(clr), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .full(full), .sh_start(sh_start), .sh_count(sh_count),
        .sh_arith(sh_arith), .sh_busy(sh_busy), .sh_bit_valid(sh_bit_valid),
        .sh_bit(sh_bit), .sh_done(sh_done), .rd_start(rd_start), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_ready(rd_ready), .regout(regout)
    );

    mmul_opreg dut_wide (
        .clk(clk), .rst(b_rst), .clr(b_clr), .ld_valid(b_ld_valid), .ld_data(b_ld_data),
        .ld_ready(b_ld_ready), .full(b_full), .sh_start(1'b0), .sh_count(9'd0),
        .sh_arith(1'b0), .sh_busy(b_sh_busy), .sh_bit_valid(b_sh_bit_valid),
        .sh_bit(b_sh_bit), .sh_done(b_sh_done), .rd_start(1'b0), .rd_valid(b_rd_valid),
        .rd_data(b_rd_data), .rd_ready(1'b0), .regout(b_regout)
    );

    function automatic logic [31:0] ref_shift(input logic [31:0] v, input int n, input bit a);
        logic signed [31:0] s;
        s = v;
        if (n >= W) return a ? {32{v[31]}} : 32'd0;
        if (a) return s >>> n;
        return v >> n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reload(input logic [31:0] v);
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        for (int i = 0; i < NW; i++) begin
            ld_valid = 1'b1;
            ld_data  = v[8*i +: 8];
            for (int k = 0; k < 5 && ld_ready !== 1'b1; k++) step();
            step();
        end
        ld_valid = 1'b0;
        m = v;
    endtask

    task automatic run_shift(input int cnt, input bit arith, output int busy_n,
                             output logic [63:0] bits, output int done_at, output bit vmis);
        busy_n = 0; bits = '0; done_at = -1; vmis = 1'b0;
        sh_start = 1'b1; sh_count = CW'(cnt); sh_arith = arith;
        step();
        sh_start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (sh_bit_valid !== sh_busy) vmis = 1'b1;
            if (sh_busy === 1'b1) begin bits[busy_n] = sh_bit; busy_n++; end
            if (sh_done === 1'b1) begin done_at = c; break; end
            step();
        end
    endtask

    // mode 0: always ready, 1: toggle 1,0,1,0..., 2: random
    task automatic run_unload(input int mode, output logic [31:0] got, output int hs,
                              output int cyc, output bit unstable, output bit first_ok);
        logic [7:0] hold;
        bit stalled;
        got = '0; hs = 0; cyc = 0; unstable = 1'b0;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        first_ok = rd_valid === 1'b1;
        for (int c = 0; c < 60 && rd_valid === 1'b1; c++) begin
            rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0)
                     : ($urandom_range(0, 1) == 1 || c % 3 == 2);
            hold = rd_data;
            if (rd_ready && hs < NW) got[8*hs +: 8] = rd_data;
            if (rd_ready) hs++;
            stalled = !rd_ready;
            step();
            cyc++;
            if (stalled && rd_valid === 1'b1 && rd_data !== hold) unstable = 1'b1;
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; b_rst = 1'b1;
        step(); step();
        rst = 1'b0; b_rst = 1'b0;
        checks++; if (regout !== 32'h0) begin errors++; $display("FAIL reset_regout got %h want 0", regout); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if ({sh_busy, sh_bit_valid, sh_done, rd_valid} !== 4'b0) begin errors++; $display("FAIL reset_status got %b want 0000", {sh_busy, sh_bit_valid, sh_done, rd_valid}); end
        checks++; if (b_regout !== 256'h0 || b_full !== 1'b0) begin errors++; $display("FAIL reset_wide got full=%b regout=%h", b_full, b_regout); end
        step();
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
    endtask

    task automatic test_load();
        logic [31:0] v;
        v = 32'h44332211;
        clr = 1'b1; step(); clr = 1'b0; step();
        for (int i = 0; i < NW; i++) begin
            checks++; if (ld_ready !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL load_ready_w%0d got ready=%b full=%b want 1 0", i, ld_ready, full); end
            ld_valid = 1'b1;
            ld_data  = v[8*i +: 8];
            step();
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL load_full got %b want 1", full); end
        checks++; if (regout !== v) begin errors++; $display("FAIL load_regout got %h want %h", regout, v); end
        ld_data = 8'h55;
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL load_5th_ready got %b want 0", ld_ready); end
        step();
        ld_valid = 1'b0;
        checks++; if (regout !== v) begin errors++; $display("FAIL load_5th_regout got %h want %h", regout, v); end
        m = v;
    endtask

    task automatic test_shift_logical();
        int busy_n, done_at;
        logic [63:0] bits;
        bit vmis;
        reload(32'h80000003);
        run_shift(2, 1'b0, busy_n, bits, done_at, vmis);
        checks++; if (bits[1:0] !== 2'b11 || busy_n != 2) begin errors++; $display("FAIL lsh_bits got %b n=%0d want 11 n=2", bits[1:0], busy_n); end
        checks++; if (done_at != 3) begin errors++; $display("FAIL lsh_done_cycle got %0d want 3", done_at); end
        checks++; if (regout !== 32'h20000000) begin errors++; $display("FAIL lsh_regout got %h want 20000000", regout); end
        checks++; if (vmis || full !== 1'b1) begin errors++; $display("FAIL lsh_valid_full got vmis=%b full=%b want 0 1", vmis, full); end
        step();
        checks++; if (sh_done !== 1'b0) begin errors++; $display("FAIL lsh_done_pulse got %b want 0", sh_done); end
    endtask

    task automatic test_shift_arith_clamp();
        int busy_n, done_at;
        logic [63:0] bits;
        bit vmis;
        reload(32'h80000000);
        run_shift(33, 1'b1, busy_n, bits, done_at, vmis);
        checks++; if (busy_n != 32 || done_at != 33) begin errors++; $display("FAIL ash_clamp_timing got busy=%0d done=%0d want 32 33", busy_n, done_at); end
        checks++; if (regout !== 32'hFFFFFFFF) begin errors++; $display("FAIL ash_clamp_regout got %h want ffffffff", regout); end
        checks++; if (bits[31:0] !== 32'h80000000) begin errors++; $display("FAIL ash_clamp_bits got %h want 80000000", bits[31:0]); end
        run_shift(0, 1'b1, busy_n, bits, done_at, vmis);
        checks++; if (busy_n != 0 || done_at != 1) begin errors++; $display("FAIL sh_zero_timing got busy=%0d done=%0d want 0 1", busy_n, done_at); end
        checks++; if (regout !== 32'hFFFFFFFF) begin errors++; $display("FAIL sh_zero_regout got %h want ffffffff", regout); end
    endtask

    task automatic test_unload();
        logic [31:0] got;
        int hs, cyc;
        bit unstable, first_ok;
        reload(32'h44332211);
        run_unload(1, got, hs, cyc, unstable, first_ok);
        checks++; if (!first_ok) begin errors++; $display("FAIL unl_first_valid got 0 want 1"); end
        checks++; if (got !== 32'h44332211 || hs != NW) begin errors++; $display("FAIL unl_words got %h hs=%0d want 44332211 hs=4", got, hs); end
        checks++; if (unstable) begin errors++; $display("FAIL unl_stall_stable got unstable want stable"); end
        checks++; if (regout !== 32'h44332211 || full !== 1'b1) begin errors++; $display("FAIL unl_restore got %h full=%b want 44332211 1", regout, full); end
        run_unload(0, got, hs, cyc, unstable, first_ok);
        checks++; if (cyc != NW || got !== 32'h44332211) begin errors++; $display("FAIL unl_fast got cyc=%0d %h want 4 44332211", cyc, got); end
    endtask

    task automatic test_priority();
        bit saw_rd;
        int done_at;
        reload(32'h12345678);
        sh_start = 1'b1; rd_start = 1'b1; sh_count = CW'(3); sh_arith = 1'b0;
        step();
        sh_start = 1'b0; rd_start = 1'b0;
        checks++; if (sh_busy !== 1'b1) begin errors++; $display("FAIL prio_shift got busy=%b want 1", sh_busy); end
        saw_rd = 1'b0; done_at = -1;
        for (int c = 1; c <= 10; c++) begin
            if (rd_valid === 1'b1) saw_rd = 1'b1;
            if (sh_done === 1'b1) begin done_at = c; break; end
            step();
        end
        step();
        if (rd_valid === 1'b1) saw_rd = 1'b1;
        checks++; if (saw_rd || done_at != 4) begin errors++; $display("FAIL prio_no_unload got rd_seen=%b done=%0d want 0 4", saw_rd, done_at); end
        checks++; if (regout !== 32'h02468ACF) begin errors++; $display("FAIL prio_regout got %h want 02468acf", regout); end
    endtask

    task automatic test_clear_reset();
        bit saw_done;
        reload(32'hDEADBEEF);
        sh_start = 1'b1; sh_count = CW'(10); sh_arith = 1'b1;
        step();
        sh_start = 1'b0;
        step(); step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (regout !== 32'h0 || full !== 1'b0) begin errors++; $display("FAIL clr_shift_state got %h full=%b want 0 0", regout, full); end
        checks++; if ({sh_busy, sh_bit_valid, sh_done} !== 3'b0) begin errors++; $display("FAIL clr_shift_status got %b want 000", {sh_busy, sh_bit_valid, sh_done}); end
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin step(); if (sh_done === 1'b1 || sh_busy === 1'b1) saw_done = 1'b1; end
        checks++; if (saw_done) begin errors++; $display("FAIL clr_no_done got activity want none"); end
        reload(32'hCAFEF00D);
        rd_start = 1'b1; step(); rd_start = 1'b0;
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (regout !== 32'h0 || full !== 1'b0 || rd_valid !== 1'b0 || sh_busy !== 1'b0) begin errors++; $display("FAIL rst_unload got %h full=%b rd_valid=%b busy=%b want 0 0 0 0", regout, full, rd_valid, sh_busy); end
    endtask

    task automatic test_wide();
        logic [255:0] exp;
        b_clr = 1'b1; step(); b_clr = 1'b0; step();
        for (int i = 0; i < 16; i++) begin
            b_ld_valid = 1'b1;
            b_ld_data  = 16'(i + 1);
            exp[16*i +: 16] = 16'(i + 1);
            for (int k = 0; k < 5 && b_ld_ready !== 1'b1; k++) step();
            step();
        end
        b_ld_valid = 1'b0;
        checks++; if (b_regout[15:0] !== 16'h0001 || b_regout[255:240] !== 16'h0010) begin errors++; $display("FAIL wide_ends got %h %h want 0001 0010", b_regout[15:0], b_regout[255:240]); end
        checks++; if (b_regout !== exp || b_full !== 1'b1) begin errors++; $display("FAIL wide_all got full=%b %h", b_full, b_regout); end
    endtask

    task automatic test_random();
        int busy_n, done_at, n, cnt, hs, cyc;
        logic [63:0] bits, mask;
        logic [31:0] want, got;
        bit vmis, arith, unstable, first_ok;
        for (int it = 0; it < 30; it++) begin
            if (it % 4 == 0) reload($urandom);
            if ($urandom_range(0, 2) != 2) begin
                cnt = $urandom_range(0, 40);
                arith = $urandom_range(0, 1) == 1;
                n = cnt > W ? W : cnt;
                want = ref_shift(m, n, arith);
                mask = (n == 0) ? 64'd0 : ((64'd1 << n) - 1);
                run_shift(cnt, arith, busy_n, bits, done_at, vmis);
                checks++; if (busy_n != n || done_at != n + 1 || vmis) begin errors++; $display("FAIL rnd_shift_timing it=%0d cnt=%0d got busy=%0d done=%0d want %0d %0d", it, cnt, busy_n, done_at, n, n + 1); end
                checks++; if (regout !== want) begin errors++; $display("FAIL rnd_shift_regout it=%0d got %h want %h", it, regout, want); end
                checks++; if ((bits & mask) !== ({32'd0, m} & mask)) begin errors++; $display("FAIL rnd_shift_bits it=%0d got %h want %h", it, bits & mask, {32'd0, m} & mask); end
                m = want;
            end else begin
                run_unload(2, got, hs, cyc, unstable, first_ok);
                checks++; if (!first_ok || got !== m || hs != NW || unstable) begin errors++; $display("FAIL rnd_unload it=%0d got %h hs=%0d want %h", it, got, hs, m); end
                checks++; if (regout !== m || full !== 1'b1) begin errors++; $display("FAIL rnd_unload_restore it=%0d got %h want %h", it, regout, m); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; ld_valid = 1'b0; ld_data = '0;
        sh_start = 1'b0; sh_count = '0; sh_arith = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
        b_rst = 1'b1; b_clr = 1'b0; b_ld_valid = 1'b0; b_ld_data = '0;
        m = '0;
        test_reset();
        test_load();
        test_shift_logical();
        test_shift_arith_clamp();
        test_unload();
        test_priority();
        test_clear_reset();
        test_wide();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
